// File: rtl/fifo_pkg.sv
// Shared constants and width helpers for the synchronous FIFO family.
package fifo_pkg;

  localparam int FWFT_OFF = 0;
  localparam int FWFT_ON  = 1;

  function automatic int addrWidth(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int ptrWidth(input int depth);
    return addrWidth(depth) + 1;
  endfunction

  function automatic bit isPow2(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/sync_fifo_if.sv
// Write/read handshake, status flags and level of a sync_fifo bundled as one interface.
interface sync_fifo_if
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
);

  logic                        flush;
  logic                        wr_en;
  logic [DATA_WIDTH-1:0]       wr_data;
  logic                        full;
  logic                        almost_full;
  logic                        rd_en;
  logic [DATA_WIDTH-1:0]       rd_data;
  logic                        rd_valid;
  logic                        empty;
  logic                        almost_empty;
  logic [ptrWidth(DEPTH)-1:0]  level;
  logic                        overflow;
  logic                        underflow;

  modport master (
    output flush, wr_en, wr_data, rd_en,
    input  full, almost_full, rd_data, rd_valid, empty, almost_empty, level, overflow, underflow
  );

  modport slave (
    input  flush, wr_en, wr_data, rd_en,
    output full, almost_full, rd_data, rd_valid, empty, almost_empty, level, overflow, underflow
  );

endinterface

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16
) (
  input  logic                          clk,
  input  logic                          i_wrEn,
  input  logic [addrWidth(DEPTH)-1:0]   i_wrAddr,
  input  logic [DATA_WIDTH-1:0]         i_wrData,
  input  logic [addrWidth(DEPTH)-1:0]   i_rdAddr,
  output logic [DATA_WIDTH-1:0]         o_rdData
);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
  end

  assign o_rdData = r_mem[i_rdAddr];

endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO with binary wrap pointers, level count, sticky error flags
// and either a registered read port or first-word-fall-through output.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 16,
  parameter int FWFT       = 0,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input logic         clk,
  input logic         rst,
  sync_fifo_if.slave  bus
);

  localparam int ADDR_W = addrWidth(DEPTH);
  localparam int PTR_W  = ptrWidth(DEPTH);
  localparam logic [PTR_W-1:0] AF_LVL = PTR_W'(AF_LEVEL);
  localparam logic [PTR_W-1:0] AE_LVL = PTR_W'(AE_LEVEL);

  if (!isPow2(DEPTH) || AE_LEVEL < 0 || AE_LEVEL >= AF_LEVEL || AF_LEVEL > DEPTH) begin : g_badParams
    $error("sync_fifo: DEPTH must be a power of two >= 2 and 0 <= AE_LEVEL < AF_LEVEL <= DEPTH");
  end

  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [PTR_W-1:0]      r_level;
  logic                  r_overflow;
  logic                  r_underflow;
  logic                  w_full;
  logic                  w_empty;
  logic                  w_wrAcc;
  logic                  w_rdAcc;
  logic                  w_memWe;
  logic [DATA_WIDTH-1:0] w_memData;

  // Full when the pointers address the same slot but sit on different laps.
  assign w_full  = (r_wrPtr[ADDR_W-1:0] == r_rdPtr[ADDR_W-1:0]) && (r_wrPtr[ADDR_W] != r_rdPtr[ADDR_W]);
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_wrAcc = bus.wr_en && !w_full;
  assign w_rdAcc = bus.rd_en && !w_empty;
  assign w_memWe = w_wrAcc && !bus.flush && !rst;

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk      (clk),
    .i_wrEn   (w_memWe),
    .i_wrAddr (r_wrPtr[ADDR_W-1:0]),
    .i_wrData (bus.wr_data),
    .i_rdAddr (r_rdPtr[ADDR_W-1:0]),
    .o_rdData (w_memData)
  );

  always_ff @(posedge clk) begin
    if (rst || bus.flush) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_level     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wrAcc) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_rdAcc) r_rdPtr <= r_rdPtr + PTR_W'(1);
      if (w_wrAcc && !w_rdAcc) begin
        r_level <= r_level + PTR_W'(1);
      end else if (!w_wrAcc && w_rdAcc) begin
        r_level <= r_level - PTR_W'(1);
      end
      if (bus.wr_en && w_full)  r_overflow  <= 1'b1;
      if (bus.rd_en && w_empty) r_underflow <= 1'b1;
    end
  end

  assign bus.full         = w_full;
  assign bus.empty        = w_empty;
  assign bus.level        = r_level;
  assign bus.almost_full  = (r_level >= AF_LVL);
  assign bus.almost_empty = (r_level <= AE_LVL);
  assign bus.overflow     = r_overflow;
  assign bus.underflow    = r_underflow;

  if (FWFT == FWFT_ON) begin : g_fwft
    // Head word is presented combinationally; zero while nothing is stored.
    assign bus.rd_data  = w_empty ? '0 : w_memData;
    assign bus.rd_valid = !w_empty;
  end else begin : g_regRead
    logic [DATA_WIDTH-1:0] r_rdData;
    logic                  r_rdValid;

    always_ff @(posedge clk) begin
      if (rst) begin
        r_rdData  <= '0;
        r_rdValid <= 1'b0;
      end else if (bus.flush) begin
        r_rdValid <= 1'b0;
      end else begin
        r_rdValid <= w_rdAcc;
        if (w_rdAcc) r_rdData <= w_memData;
      end
    end

    assign bus.rd_data  = r_rdData;
    assign bus.rd_valid = r_rdValid;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed self-checking bench for sync_fifo: registered-read instance plus a FWFT instance.
module tb_sync_fifo;
  import fifo_pkg::*;

  localparam int DW    = 32;
  localparam int DEPTH = 8;

  logic clk;
  logic rst;
  int   compareCount;
  int   mismatchCount;

  sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) regBus ();
  sync_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) fwftBus ();

  sync_fifo #(
    .DATA_WIDTH (DW), .DEPTH (DEPTH), .FWFT (FWFT_OFF), .AF_LEVEL (6), .AE_LEVEL (2)
  ) u_dutReg (
    .clk (clk),
    .rst (rst),
    .bus (regBus)
  );

  sync_fifo #(
    .DATA_WIDTH (DW), .DEPTH (DEPTH), .FWFT (FWFT_ON), .AF_LEVEL (6), .AE_LEVEL (2)
  ) u_dutFwft (
    .clk (clk),
    .rst (rst),
    .bus (fwftBus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of inputs into both FIFOs, then sample just after the edge.
  task automatic applyStimulus(input logic wr, input logic [31:0] data, input logic rd, input logic fl);
    regBus.wr_en    = wr;
    regBus.wr_data  = data;
    regBus.rd_en    = rd;
    regBus.flush    = fl;
    fwftBus.wr_en   = wr;
    fwftBus.wr_data = data;
    fwftBus.rd_en   = rd;
    fwftBus.flush   = fl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    compareCount  = 0;
    mismatchCount = 0;
    rst = 1'b1;
    regBus.wr_en  = 1'b0; regBus.wr_data  = '0; regBus.rd_en  = 1'b0; regBus.flush  = 1'b0;
    fwftBus.wr_en = 1'b0; fwftBus.wr_data = '0; fwftBus.rd_en = 1'b0; fwftBus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    checkOutput("rst level",        regBus.level,        0);
    checkOutput("rst empty",        regBus.empty,        1);
    checkOutput("rst almost_empty", regBus.almost_empty, 1);
    checkOutput("rst full",         regBus.full,         0);
    checkOutput("rst almost_full",  regBus.almost_full,  0);
    checkOutput("rst rd_valid",     regBus.rd_valid,     0);
    checkOutput("rst rd_data",      regBus.rd_data,      0);
    checkOutput("rst overflow",     regBus.overflow,     0);
    checkOutput("rst underflow",    regBus.underflow,    0);
    checkOutput("fwft rst empty",   fwftBus.empty,       1);

    // FWFT: word visible one cycle after write, with no read request
    applyStimulus(1'b1, 32'h11, 1'b0, 1'b0);
    checkOutput("fwft empty after write", fwftBus.empty,    0);
    checkOutput("fwft rd_data head",      fwftBus.rd_data,  32'h11);
    checkOutput("fwft rd_valid",          fwftBus.rd_valid, 1);
    checkOutput("reg level 1",            regBus.level,     1);
    checkOutput("reg no rd_valid",        regBus.rd_valid,  0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("fwft empty after ack",   fwftBus.empty,    1);
    checkOutput("fwft rd_valid low",      fwftBus.rd_valid, 0);
    checkOutput("reg rd_data 0x11",       regBus.rd_data,   32'h11);
    checkOutput("reg rd_valid pulse",     regBus.rd_valid,  1);
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0);
    checkOutput("reg rd_valid drops",     regBus.rd_valid,  0);
    checkOutput("reg rd_data holds",      regBus.rd_data,   32'h11);

    // Fill 0..7
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, 32'(i), 1'b0, 1'b0);
      checkOutput($sformatf("fill level %0d", i), regBus.level, 32'(i + 1));
      checkOutput($sformatf("fill almost_full %0d", i), regBus.almost_full, (i + 1 >= 6) ? 32'd1 : 32'd0);
      checkOutput($sformatf("fill full %0d", i), regBus.full, (i == DEPTH - 1) ? 32'd1 : 32'd0);
    end

    // Full boundary: read wins, 0xAA rejected
    applyStimulus(1'b1, 32'hAA, 1'b1, 1'b0);
    checkOutput("fullsim level",    regBus.level,    7);
    checkOutput("fullsim overflow", regBus.overflow, 1);
    checkOutput("fullsim full",     regBus.full,     0);
    checkOutput("fullsim rd_data",  regBus.rd_data,  0);
    checkOutput("fullsim rd_valid", regBus.rd_valid, 1);

    // Drain remaining 1..7
    for (int i = 1; i < DEPTH; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput($sformatf("drain data %0d", i), regBus.rd_data, 32'(i));
      checkOutput($sformatf("drain valid %0d", i), regBus.rd_valid, 1);
    end
    checkOutput("drain empty",     regBus.empty,     1);
    checkOutput("drain level",     regBus.level,     0);
    checkOutput("drain overflow",  regBus.overflow,  1);

    // Wrap: keep level at 3 while streaming 0x100+i
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 32'h100 + 32'(i), 1'b0, 1'b0);
    checkOutput("wrap prefill level", regBus.level, 3);
    for (int i = 3; i < 20; i++) begin
      applyStimulus(1'b1, 32'h100 + 32'(i), 1'b1, 1'b0);
      checkOutput($sformatf("wrap data %0d", i), regBus.rd_data, 32'h100 + 32'(i - 3));
      checkOutput($sformatf("wrap level %0d", i), regBus.level, 3);
    end
    for (int i = 17; i < 20; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      checkOutput($sformatf("wrap tail %0d", i), regBus.rd_data, 32'h100 + 32'(i));
    end
    checkOutput("wrap empty",     regBus.empty,     1);
    checkOutput("wrap underflow", regBus.underflow, 0);

    // Empty boundary: write wins, read flagged
    applyStimulus(1'b1, 32'h55, 1'b1, 1'b0);
    checkOutput("emptysim level",     regBus.level,     1);
    checkOutput("emptysim underflow", regBus.underflow, 1);
    checkOutput("emptysim rd_valid",  regBus.rd_valid,  0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("emptysim rd_data",   regBus.rd_data,   32'h55);
    checkOutput("emptysim rd_valid2", regBus.rd_valid,  1);

    // Flush at level 5 with sticky flags set
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    checkOutput("preflush level",    regBus.level,    5);
    checkOutput("preflush overflow", regBus.overflow, 1);
    applyStimulus(1'b1, 32'h99, 1'b1, 1'b1);
    checkOutput("flush level",     regBus.level,     0);
    checkOutput("flush empty",     regBus.empty,     1);
    checkOutput("flush overflow",  regBus.overflow,  0);
    checkOutput("flush underflow", regBus.underflow, 0);
    checkOutput("flush rd_valid",  regBus.rd_valid,  0);
    checkOutput("flush rd_data",   regBus.rd_data,   32'h55);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1);
    checkOutput("flush masks underflow", regBus.underflow, 0);

    // Reset mid-operation discards data and has priority over a write
    applyStimulus(1'b1, 32'h77, 1'b0, 1'b0);
    checkOutput("prerst level", regBus.level, 1);
    rst = 1'b1;
    applyStimulus(1'b1, 32'h99, 1'b0, 1'b0);
    rst = 1'b0;
    checkOutput("midrst empty",   regBus.empty,   1);
    checkOutput("midrst level",   regBus.level,   0);
    checkOutput("midrst rd_data", regBus.rd_data, 0);
    applyStimulus(1'b1, 32'h88, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("postrst rd_data",  regBus.rd_data,  32'h88);
    checkOutput("postrst rd_valid", regBus.rd_valid, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
